// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - multi-slot circular fetch queue; optional 0-cycle bypass under FETCH_QUEUE_BYPASS_EN
module fetch_queue #(
  parameter int IN_WIDTH  = 2,
  parameter int OUT_WIDTH = 2,
  parameter int DEPTH     = 16,
  parameter int DATA_W    = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic [IN_WIDTH-1:0]            in_valid,
  input  logic [IN_WIDTH*DATA_W-1:0]     in_data,
  output logic                           in_allowin,
  output logic [OUT_WIDTH-1:0]           out_valid,
  output logic [OUT_WIDTH*DATA_W-1:0]    out_data,
  input  logic                           out_ready,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int BYP_W = (IN_WIDTH < OUT_WIDTH) ? IN_WIDTH : OUT_WIDTH;
`endif

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     n_in, n_out, n_pop, n_skip, n_wr;
  logic              push, pop;
  logic              in_valid_contig;

  assign count = count_q;

  // Admission depends only on registered occupancy so it never waits on the consumer
  always_comb begin
    in_allowin = (CW'(DEPTH) - count_q) >= CW'(IN_WIDTH);
  end

  // Number of offered input instructions
  always_comb begin
    n_in = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      n_in = n_in + CW'(in_valid[i]);
    end
  end

  assign push = in_allowin & (|in_valid) & ~flush;
  assign pop  = out_ready & ~flush;

  // Present the oldest entries; with bypass on an empty queue, inputs go straight out
  always_comb begin
    out_valid = '0;
    out_data  = '0;
    for (int i = 0; i < OUT_WIDTH; i++) begin
      out_valid[i]                 = (CW'(i) < count_q) & ~flush;
      out_data[i*DATA_W +: DATA_W] = mem_q[head_q + PW'(i)];
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    if ((count_q == '0) && !flush) begin
      for (int i = 0; i < BYP_W; i++) begin
        out_valid[i]                 = in_valid[i];
        out_data[i*DATA_W +: DATA_W] = in_data[i*DATA_W +: DATA_W];
      end
    end
`endif
  end

  // Number of slots presented this cycle
  always_comb begin
    n_out = '0;
    for (int i = 0; i < OUT_WIDTH; i++) begin
      n_out = n_out + CW'(out_valid[i]);
    end
  end

  // Split the handshake into entries leaving storage, entries skipped by bypass, entries written
  always_comb begin
    n_pop  = pop ? n_out : '0;
    n_skip = '0;
`ifdef FETCH_QUEUE_BYPASS_EN
    if ((count_q == '0) && !flush) begin
      n_pop = '0;
      if (pop) begin
        n_skip = n_out;
      end
    end
`endif
    n_wr = push ? (n_in - n_skip) : '0;
  end

  // Pointer and occupancy update; flush wins over any push or pop
  always_comb begin
    head_d  = head_q + PW'(n_pop);
    tail_d  = tail_q + PW'(n_wr);
    count_d = count_q + n_wr - n_pop;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Control state with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage is never reset; slots written in order starting at tail
  always_ff @(posedge clk) begin
    for (int j = 0; j < IN_WIDTH; j++) begin
      if (push && in_valid[j] && (CW'(j) >= n_skip)) begin
        mem_q[tail_q + PW'(CW'(j) - n_skip)] <= in_data[j*DATA_W +: DATA_W];
      end
    end
  end

  assign in_valid_contig = ((in_valid & (in_valid + IN_WIDTH'(1))) == '0);

  a_in_valid_contig: assert property (@(posedge clk) disable iff (reset) in_valid_contig);

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed and random checks of fetch_queue against a queue-based model
module tb_fetch_queue;

  localparam int IW = 2;
  localparam int OW = 2;
  localparam int D  = 8;
  localparam int DW = 64;

  logic           clk = 1'b0;
  logic           reset;
  logic           flush;
  logic [IW-1:0]  in_valid;
  logic [IW*DW-1:0] in_data;
  logic           in_allowin;
  logic [OW-1:0]  out_valid;
  logic [OW*DW-1:0] out_data;
  logic           out_ready;
  logic [3:0]     count;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] mq [$];

  fetch_queue #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DEPTH(D), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_allowin(in_allowin),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    int n;
    logic [1:0] ev;
    logic [DW-1:0] ed [2];
    n = mq.size();
    ev = '0;
    ed[0] = '0;
    ed[1] = '0;
    for (int i = 0; i < OW; i++) begin
      if (i < n && !flush) begin
        ev[i] = 1'b1;
        ed[i] = mq[i];
      end
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    if (n == 0 && !flush) begin
      for (int i = 0; i < OW; i++) begin
        if (in_valid[i]) begin
          ev[i] = 1'b1;
          ed[i] = in_data[i*DW +: DW];
        end
      end
    end
`endif
    chk({tag, "_count"}, 64'(count), 64'(n));
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(ev));
    chk({tag, "_allowin"}, 64'(in_allowin), 64'((D - n) >= IW));
    for (int i = 0; i < OW; i++) begin
      if (ev[i]) chk({tag, "_data"}, out_data[i*DW +: DW], ed[i]);
    end
  endtask

  task automatic step(input logic [1:0] v, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                      input logic rdy, input logic fl);
    int n;
    @(negedge clk);
    in_valid  = v;
    in_data   = {d1, d0};
    out_ready = rdy;
    flush     = fl;
    #1 check_model("cyc");
    @(posedge clk);
    n = mq.size();
    if (fl) begin
      mq.delete();
    end else begin
`ifdef FETCH_QUEUE_BYPASS_EN
      if (n == 0) begin
        if (v[0]) mq.push_back(d0);
        if (v[1]) mq.push_back(d1);
        if (rdy) mq.delete();
      end else begin
`else
      begin
`endif
        if (rdy) begin
          for (int k = 0; k < OW && k < n; k++) void'(mq.pop_front());
        end
        if ((D - n) >= IW) begin
          if (v[0]) mq.push_back(d0);
          if (v[1]) mq.push_back(d1);
        end
      end
    end
    #1;
  endtask

  logic [DW-1:0] a, b, c, x, y, p, q;
  int pick;

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
    #3;
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_allowin", 64'(in_allowin), 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // first pair lands one cycle later
    a = rnd(); b = rnd();
    step(2'b11, a, b, 1'b0, 1'b0);
    chk("first_count", 64'(count), 64'd2);
    chk("first_valid", 64'(out_valid), 64'h3);
    chk("first_slot0", out_data[63:0], a);
    chk("first_slot1", out_data[127:64], b);

    // fill to capacity, further offers ignored
    repeat (3) step(2'b11, rnd(), rnd(), 1'b0, 1'b0);
    chk("full_count", 64'(count), 64'd8);
    chk("full_allowin", 64'(in_allowin), 64'd0);
    step(2'b11, rnd(), rnd(), 1'b0, 1'b0);
    chk("full_hold_count", 64'(count), 64'd8);
    chk("full_hold_slot0", out_data[63:0], a);
    repeat (4) step(2'b00, '0, '0, 1'b1, 1'b0);
    chk("drained_count", 64'(count), 64'd0);

    // single-slot push then pop
    c = rnd();
    step(2'b01, c, '0, 1'b0, 1'b0);
    chk("single_count", 64'(count), 64'd1);
    chk("single_valid", 64'(out_valid), 64'h1);
    chk("single_data", out_data[63:0], c);
    step(2'b00, '0, '0, 1'b1, 1'b0);
    chk("single_gone", 64'(out_valid), 64'd0);

    // walk head to 5, then straddle the wrap point
    repeat (2) begin
      step(2'b11, rnd(), rnd(), 1'b0, 1'b0);
      step(2'b00, '0, '0, 1'b1, 1'b0);
    end
    repeat (3) step(2'b11, rnd(), rnd(), 1'b0, 1'b0);
    x = rnd(); y = rnd();
    step(2'b11, x, y, 1'b1, 1'b0);
    chk("wrap_count", 64'(count), 64'd6);
    repeat (3) step(2'b00, '0, '0, 1'b1, 1'b0);
    chk("wrap_drained", 64'(count), 64'd0);

    // flush with concurrent push and pop
    step(2'b01, rnd(), '0, 1'b0, 1'b0);
    repeat (2) step(2'b11, rnd(), rnd(), 1'b0, 1'b0);
    chk("preflush_count", 64'(count), 64'd5);
    p = rnd(); q = rnd();
    step(2'b11, p, q, 1'b1, 1'b1);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    step(2'b00, '0, '0, 1'b1, 1'b0);
    chk("postflush_valid", 64'(out_valid), 64'd0);

    // asynchronous reset mid-cycle
    repeat (3) step(2'b11, rnd(), rnd(), 1'b0, 1'b0);
    chk("prereset_count", 64'(count), 64'd6);
    @(negedge clk);
    in_valid = '0;
    #2 reset = 1'b1;
    #1;
    chk("async_count", 64'(count), 64'd0);
    chk("async_valid", 64'(out_valid), 64'd0);
    chk("async_allowin", 64'(in_allowin), 64'd1);
    mq.delete();
    @(negedge clk);
    reset = 1'b0;

`ifdef FETCH_QUEUE_BYPASS_EN
    c = rnd();
    step(2'b01, c, '0, 1'b1, 1'b0);
    chk("bypass_count", 64'(count), 64'd0);
`endif

    // random traffic
    for (int t = 0; t < 400; t++) begin
      pick = $urandom_range(0, 2);
      step((pick == 0) ? 2'b00 : (pick == 1) ? 2'b01 : 2'b11, rnd(), rnd(),
           1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
